// File: rtl/cdc_fifo_clear_initiator.sv
// Clear-side sequencer for a clearable CDC FIFO endpoint: isolates the stream,
// issues a one-cycle clear, tracks the clear-pending handshake, and reports done/timeout.
module cdc_fifo_clear_initiator #(
    parameter int STALL_LIMIT = 1024,
    parameter int ACK_TIMEOUT = 256,
    parameter int CNT_W       = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic             up_valid_i,
    output logic             up_ready_o,
    output logic             fifo_valid_o,
    input  logic             fifo_ready_i,
    output logic             fifo_clear_o,
    input  logic             fifo_clear_pending_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] clear_count_o
);

    localparam int STALL_W = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
    localparam int TO_W    = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISOLATE,
        S_CLEAR,
        S_WAIT_RISE,
        S_WAIT_FALL
    } state_e;

    state_e             state_q, state_d;
    logic               remote_q, remote_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   clear_count_q, clear_count_d;

    logic            stalled;
    logic            watchdog_fire;
    logic [TO_W-1:0] to_cnt_inc;
    logic            to_expired;

    assign stalled       = up_valid_i & ~fifo_ready_i;
    assign watchdog_fire = (STALL_LIMIT != 0) && stalled &&
                           (stall_cnt_q == STALL_W'(STALL_LIMIT - 1));
    assign to_cnt_inc    = to_cnt_q + TO_W'(1);
    assign to_expired    = (to_cnt_inc == TO_W'(ACK_TIMEOUT));

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        remote_d      = remote_q;
        stall_cnt_d   = stall_cnt_q;
        to_cnt_d      = to_cnt_q;
        done_d        = 1'b0;
        timeout_d     = timeout_q;
        clear_count_d = clear_count_q;

        case (state_q)
            S_IDLE: begin
                if (!stalled) begin
                    stall_cnt_d = '0;
                end else if (stall_cnt_q != STALL_W'(STALL_LIMIT)) begin
                    stall_cnt_d = stall_cnt_q + STALL_W'(1);
                end
                // A far-side clear outranks a local request in the same cycle.
                if (fifo_clear_pending_i) begin
                    state_d     = S_WAIT_FALL;
                    remote_d    = 1'b1;
                    stall_cnt_d = '0;
                end else if (req_i || watchdog_fire) begin
                    state_d     = S_ISOLATE;
                    timeout_d   = 1'b0;
                    stall_cnt_d = '0;
                end
            end
            S_ISOLATE: state_d = S_CLEAR;
            S_CLEAR: begin
                to_cnt_d = '0;
                state_d  = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                if (fifo_clear_pending_i) begin
                    state_d = S_WAIT_FALL;
                end else if (to_expired) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_inc;
                end
            end
            S_WAIT_FALL: begin
                if (!fifo_clear_pending_i) begin
                    state_d = S_IDLE;
                    if (remote_q) begin
                        remote_d = 1'b0;
                    end else begin
                        done_d = 1'b1;
                        if (clear_count_q != '1) clear_count_d = clear_count_q + CNT_W'(1);
                    end
                end else if (!remote_q) begin
                    if (to_expired) begin
                        state_d   = S_IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_inc;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            remote_q      <= 1'b0;
            stall_cnt_q   <= '0;
            to_cnt_q      <= '0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            clear_count_q <= '0;
        end else begin
            state_q       <= state_d;
            remote_q      <= remote_d;
            stall_cnt_q   <= stall_cnt_d;
            to_cnt_q      <= to_cnt_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
            clear_count_q <= clear_count_d;
        end
    end

    logic gate_open;
    assign gate_open     = (state_q == S_IDLE) & ~fifo_clear_pending_i;
    assign fifo_valid_o  = up_valid_i & gate_open;
    assign up_ready_o    = fifo_ready_i & gate_open;
    assign fifo_clear_o  = (state_q == S_CLEAR);
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign timeout_o     = timeout_q;
    assign clear_count_o = clear_count_q;

endmodule

// File: tb/tb_cdc_fifo_clear_initiator.sv
// Directed bench: two instances share stimulus; A has an 8-cycle watchdog and a 2-bit
// counter, B has no watchdog and a 4-cycle ack timeout.
module tb_cdc_fifo_clear_initiator;

    logic clk_i = 1'b0;
    logic rst_i;
    logic req_i, up_valid_i, fifo_ready_i, fifo_clear_pending_i;

    logic       a_up_ready, a_fifo_valid, a_clear, a_busy, a_done, a_timeout;
    logic [1:0] a_count;
    logic       b_up_ready, b_fifo_valid, b_clear, b_busy, b_done, b_timeout;
    logic [7:0] b_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    cdc_fifo_clear_initiator #(.STALL_LIMIT(8), .ACK_TIMEOUT(16), .CNT_W(2)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i),
        .up_valid_i(up_valid_i), .up_ready_o(a_up_ready),
        .fifo_valid_o(a_fifo_valid), .fifo_ready_i(fifo_ready_i),
        .fifo_clear_o(a_clear), .fifo_clear_pending_i(fifo_clear_pending_i),
        .busy_o(a_busy), .done_o(a_done), .timeout_o(a_timeout),
        .clear_count_o(a_count)
    );

    cdc_fifo_clear_initiator #(.STALL_LIMIT(0), .ACK_TIMEOUT(4), .CNT_W(8)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i),
        .up_valid_i(up_valid_i), .up_ready_o(b_up_ready),
        .fifo_valid_o(b_fifo_valid), .fifo_ready_i(fifo_ready_i),
        .fifo_clear_o(b_clear), .fifo_clear_pending_i(fifo_clear_pending_i),
        .busy_o(b_busy), .done_o(b_done), .timeout_o(b_timeout),
        .clear_count_o(b_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic req, input logic valid, input logic ready, input logic pend);
        req_i                = req;
        up_valid_i           = valid;
        fifo_ready_i         = ready;
        fifo_clear_pending_i = pend;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Leaves the bench 1 time unit into cycle 0, reset released.
    task automatic reset_dut();
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // One fast local clear: req at 0, pending high only at 3, done at 5.
    task automatic quick_clear(input int n);
        for (int i = 0; i <= 5; i++) begin
            drive(i == 0, 1'b0, 1'b1, i == 3);
            @(negedge clk_i);
            check($sformatf("sat%0d i%0d a_done", n, i), a_done, i == 5);
            if (i == 5) begin
                check($sformatf("sat%0d a_count", n), a_count, (n > 3) ? 3 : n);
                check($sformatf("sat%0d b_count", n), b_count, n);
            end
            tick();
        end
    endtask

    initial begin
        // Reset values and gate while reset is held.
        rst_i = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        #12;
        check("rst busy", a_busy, 0);
        check("rst done", a_done, 0);
        check("rst timeout", a_timeout, 0);
        check("rst clear", a_clear, 0);
        check("rst count", a_count, 0);
        check("rst gate valid pend", a_fifo_valid, 0);
        check("rst gate ready pend", a_up_ready, 0);
        fifo_clear_pending_i = 1'b0;
        #1;
        check("rst gate valid open", a_fifo_valid, 1);
        check("rst gate ready open", a_up_ready, 1);

        // Local clear: req at 10, pending 14..19.
        reset_dut();
        for (int c = 0; c <= 25; c++) begin
            drive(c == 10, 1'b1, 1'b1, c >= 14 && c < 20);
            @(negedge clk_i);
            check($sformatf("local c%0d clear", c), a_clear, c == 12);
            check($sformatf("local c%0d up_ready", c), a_up_ready, !(c >= 11 && c <= 20));
            check($sformatf("local c%0d done", c), a_done, c == 21);
            tick();
        end
        check("local count", a_count, 1);
        check("local timeout", a_timeout, 0);

        // Watchdog: continuous stall.
        reset_dut();
        for (int c = 0; c <= 9; c++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            @(negedge clk_i);
            check($sformatf("wd c%0d a_busy", c), a_busy, c >= 8);
            check($sformatf("wd c%0d a_clear", c), a_clear, c == 9);
            check($sformatf("wd c%0d b_busy", c), b_busy, 0);
            tick();
        end

        // Watchdog: handshake at cycle 5 restarts the count.
        reset_dut();
        for (int c = 0; c <= 15; c++) begin
            drive(1'b0, 1'b1, c == 5, 1'b0);
            @(negedge clk_i);
            check($sformatf("wd2 c%0d a_busy", c), a_busy, c >= 14);
            check($sformatf("wd2 c%0d a_clear", c), a_clear, c == 15);
            tick();
        end

        // Timeout on B: pending never rises.
        reset_dut();
        for (int c = 0; c <= 11; c++) begin
            drive(c == 0 || c == 10, 1'b0, 1'b1, 1'b0);
            @(negedge clk_i);
            check($sformatf("to c%0d b_busy", c), b_busy, (c >= 1 && c <= 6) || c == 11);
            check($sformatf("to c%0d b_timeout", c), b_timeout, c >= 7 && c <= 10);
            check($sformatf("to c%0d b_done", c), b_done, 0);
            tick();
        end
        check("to b_count", b_count, 0);

        // Remote clear on B: pending 5..29.
        reset_dut();
        for (int c = 0; c <= 33; c++) begin
            drive(1'b0, 1'b1, 1'b1, c >= 5 && c < 30);
            @(negedge clk_i);
            check($sformatf("rem c%0d up_ready", c), b_up_ready, !(c >= 5 && c <= 30));
            check($sformatf("rem c%0d fifo_valid", c), b_fifo_valid, !(c >= 5 && c <= 30));
            check($sformatf("rem c%0d clear", c), b_clear, 0);
            check($sformatf("rem c%0d done", c), b_done, 0);
            check($sformatf("rem c%0d timeout", c), b_timeout, 0);
            tick();
        end
        check("rem b_count", b_count, 0);

        // Collision at 2, plus a request at 4 while busy.
        reset_dut();
        for (int c = 0; c <= 10; c++) begin
            drive(c == 2 || c == 4, 1'b0, 1'b1, c >= 2 && c <= 5);
            @(negedge clk_i);
            check($sformatf("col c%0d a_busy", c), a_busy, c >= 3 && c <= 6);
            check($sformatf("col c%0d a_clear", c), a_clear, 0);
            check($sformatf("col c%0d b_clear", c), b_clear, 0);
            check($sformatf("col c%0d a_done", c), a_done, 0);
            tick();
        end
        check("col a_count", a_count, 0);

        // Counter saturation: five local clears.
        reset_dut();
        for (int n = 1; n <= 5; n++) quick_clear(n);

        // Reset in WAIT_FALL: async return to reset values.
        for (int c = 0; c <= 5; c++) begin
            drive(c == 0, 1'b0, 1'b1, c >= 3);
            @(negedge clk_i);
            if (c == 2) check("rstwf clear in CLEAR", a_clear, 1);
            if (c == 5) check("rstwf busy before", a_busy, 1);
            if (c != 5) tick();
        end
        rst_i = 1'b1;
        #1;
        check("rstwf a_busy", a_busy, 0);
        check("rstwf a_count", a_count, 0);
        check("rstwf b_count", b_count, 0);

        // Reset in CLEAR: fifo_clear_o drops without an edge.
        reset_dut();
        for (int c = 0; c <= 2; c++) begin
            drive(c == 0, 1'b0, 1'b1, 1'b0);
            @(negedge clk_i);
            if (c != 2) tick();
        end
        check("rstclr before", a_clear, 1);
        rst_i = 1'b1;
        #1;
        check("rstclr after", a_clear, 0);

        // Pass-through after release.
        reset_dut();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk_i);
        check("pass fifo_valid", a_fifo_valid, 1);
        check("pass up_ready", a_up_ready, 1);
        check("pass busy", a_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cdc_fifo_clear_initiator.md
# cdc_fifo_clear_initiator

Single-clock sequencer that drives the clear side of a clearable CDC FIFO endpoint. It sits between an upstream stream source and the FIFO's source- or destination-side port. On a request, or when a stall watchdog fires, it isolates the stream and issues a one-cycle clear. It then tracks the FIFO's clear-pending handshake to completion and reports done or timeout. It also isolates the stream when the far side starts a clear.

## Interface
- `STALL_LIMIT`, default 1024: consecutive stalled cycles that trigger an automatic clear; 0 disables the watchdog.
- `ACK_TIMEOUT`, default 256: maximum cycles spent in WAIT_RISE plus WAIT_FALL before aborting; must be ≥ 1.
- `CNT_W`, default 8: width of `clear_count_o`.
- `clk_i`  in  1  sole clock; all logic is rising-edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_i`  in  1  clear request; sampled only in IDLE.
- `up_valid_i`  in  1  upstream valid.
- `up_ready_o`  out  1  upstream ready.
- `fifo_valid_o`  out  1  valid toward the FIFO.
- `fifo_ready_i`  in  1  ready from the FIFO.
- `fifo_clear_o`  out  1  clear pulse to the FIFO (`*_clear_i`).
- `fifo_clear_pending_i`  in  1  FIFO clear-pending (`*_clear_pending_o`).
- `busy_o`  out  1  state ≠ IDLE.
- `done_o`  out  1  one-cycle pulse when a locally issued clear completes.
- `timeout_o`  out  1  sticky; the last local clear aborted.
- `clear_count_o`  out  CNT_W  completed local clears, saturating.

## Operation
- The FSM has five states: IDLE, ISOLATE, CLEAR, WAIT_RISE, WAIT_FALL. It also has a REMOTE flag for far-side clears.
- Isolation gate, `open` = (state==IDLE) & !fifo_clear_pending_i:
  - fifo_valid_o = up_valid_i & open
  - up_ready_o = fifo_ready_i & open
  - Both are combinational.
- Stall counter (IDLE only):
  - Increments when up_valid_i & !fifo_ready_i.
  - Clears on any other IDLE cycle and on leaving IDLE.
  - Saturates at STALL_LIMIT.
- IDLE transitions, first match wins:
  - fifo_clear_pending_i=1 → WAIT_FALL with REMOTE=1. This is a far-side clear: no fifo_clear_o is issued.
  - Otherwise, req_i=1, or (STALL_LIMIT≠0 and stall count == STALL_LIMIT−1 and stalled this cycle) → ISOLATE. timeout_o clears on this transition.
- ISOLATE lasts exactly 1 cycle, then → CLEAR.
- CLEAR: fifo_clear_o=1 for exactly this cycle; timeout counter loads 0; → WAIT_RISE.
- WAIT_RISE:
  - fifo_clear_pending_i=1 → WAIT_FALL.
  - Otherwise the timeout counter increments.
- WAIT_FALL:
  - fifo_clear_pending_i=0 → IDLE.
  - If REMOTE=0: pulse done_o and increment clear_count_o (saturates at 2^CNT_W−1).
  - If REMOTE=1: clear REMOTE; no done_o and no count change.
  - Otherwise the timeout counter increments; it is not applied when REMOTE=1.
- Timeout: the counter reaches ACK_TIMEOUT in WAIT_RISE or WAIT_FALL (local clear only) → IDLE, set timeout_o, no done_o.
- req_i is ignored while busy_o=1; requests are not queued.
- Upstream sees valid dropped without a handshake during a clear. This is intended: data in flight is discarded by the clear.

## Timing
- Reset values:
  - state=IDLE, REMOTE=0, all counters 0.
  - fifo_clear_o=0, busy_o=0, done_o=0, timeout_o=0, clear_count_o=0.
  - fifo_valid_o and up_ready_o follow the gate; both are 0 if fifo_clear_pending_i=1.
- Request latency: req_i high at cycle N → ISOLATE at N+1, fifo_clear_o=1 at N+2, WAIT_RISE from N+3.
- Done latency: pending falls, sampled low at cycle M in WAIT_FALL → done_o=1 in M+1 and state IDLE in M+1.
- Watchdog: STALL_LIMIT=L with stall cycles 0..L−1 → ISOLATE at cycle L.
- Simultaneous req_i and pending rise in IDLE: the remote path wins; req_i is dropped.
- Reset mid-sequence (any state): immediate return to reset values; fifo_clear_o deasserts asynchronously.
- Pending already high on entry to WAIT_RISE: leave on the next edge, 1 cycle in WAIT_RISE.

## Test plan
- **Local clear.** req_i pulse at cycle 10; FIFO model raises pending at 14 and drops it at 20. Required: fifo_clear_o only at 12; up_ready_o=0 for 11–20; done_o at 21; clear_count_o=1.
- **Watchdog.** STALL_LIMIT=8; up_valid_i=1, fifo_ready_i=0 from cycle 0. Required: ISOLATE at 8, fifo_clear_o at 9. Also, a handshake at cycle 5 restarts the count, which moves ISOLATE to 14.
- **Timeout.** ACK_TIMEOUT=4; pending never rises. Required: IDLE after 4 WAIT_RISE cycles; timeout_o=1; no done_o; count unchanged. The next req_i clears timeout_o.
- **Remote clear.** Pending rises at cycle 5 in IDLE and falls at 30. Required: fifo_clear_o never asserts; up_ready_o and fifo_valid_o are 0 for 5–30; no done_o; no timeout even with ACK_TIMEOUT=4.
- **Collision.** req_i and pending rise in the same IDLE cycle. Required: remote path taken; fifo_clear_o stays 0. req_i while busy is ignored.
- **Reset.** rst_i asserted mid-WAIT_FALL. Required: busy_o=0 and clear_count_o=0 without a clock edge; normal pass-through after release. Also, CNT_W=2 saturates at 3 after 5 local clears.
